// File: rtl/round_pkg.sv
// rtl/round_pkg.sv - format enum, per-format Emax constants and lookup helper for the rounder flag pipe
package round_pkg;

    typedef enum logic [1:0] {
        FMT_SINGLE = 2'b00,
        FMT_DOUBLE = 2'b01,
        FMT_HALF   = 2'b10,
        FMT_RSVD   = 2'b11
    } fmt_e;

    localparam int unsigned EMAX_HALF   = 15;
    localparam int unsigned EMAX_SINGLE = 127;
    localparam int unsigned EMAX_DOUBLE = 1023;

    // Emax for a format, truncated to er_w bits. The reserved code behaves as double.
    function automatic logic [31:0] emax_of(input fmt_e f, input int unsigned er_w);
        logic [31:0] v;
        logic [31:0] mask;
        case (f)
            FMT_HALF:   v = EMAX_HALF;
            FMT_SINGLE: v = EMAX_SINGLE;
            default:    v = EMAX_DOUBLE;
        endcase
        mask = (er_w >= 32) ? '1 : ((32'd1 << er_w) - 32'd1);
        return v & mask;
    endfunction

endpackage

// File: rtl/lzc_param.sv
// rtl/lzc_param.sv - combinational leading-zero counter over a 2**LZ_W-bit vector
// Ports:
//   d_i    in  2**LZ_W  vector scanned from the MSB downward
//   cnt_o  out LZ_W+1   number of leading zeros (2**LZ_W when d_i is all zero)
module lzc_param #(
    parameter int LZ_W = 6
) (
    input  logic [2**LZ_W-1:0] d_i,
    output logic [LZ_W:0]      cnt_o
);

    localparam int W  = 2**LZ_W;
    localparam int OW = LZ_W + 1;

    logic found;

    always_comb begin
        cnt_o = OW'(W);
        found = 1'b0;
        for (int i = W - 1; i >= 0; i--) begin
            if (!found && d_i[i]) begin
                cnt_o = OW'(W - 1 - i);
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/round_flags_pipe.sv
// rtl/round_flags_pipe.sv - two-stage valid/ready pipe computing lz, TINY, OVF1 and sticky status
// Ports:
//   clk, rst_n               clock, asynchronous active-low reset
//   in_valid/in_ready        input handshake carrying fr, er, fmt
//   out_valid/out_ready      output handshake carrying lz, tiny, ovf1
//   clear_flags              clears sticky_tiny/sticky_ovf (a same-cycle set wins)
//   sticky_tiny, sticky_ovf  accumulated flags of all handshaked results
module round_flags_pipe
    import round_pkg::*;
#(
    parameter int FR_W = 57,
    parameter int ER_W = 13,
    parameter int LZ_W = 6
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [FR_W-1:0] fr,
    input  logic [ER_W-1:0] er,
    input  logic [1:0]      fmt,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [LZ_W-1:0] lz,
    output logic            tiny,
    output logic            ovf1,
    input  logic            clear_flags,
    output logic            sticky_tiny,
    output logic            sticky_ovf
);

    localparam int PAD_W = 2**LZ_W - FR_W;

    // Stage-1 combinational results from the input beat
    logic [2**LZ_W-1:0] lzc_in;
    logic [LZ_W:0]      lzc_cnt;
    logic [LZ_W-1:0]    lz_in;
    logic [ER_W-1:0]    emax_in;
    logic               ovf_in;

    // Padding ones below fr cap the count at FR_W, so the MSB of the counter never sets.
    assign lzc_in = {fr, {PAD_W{1'b1}}};

    lzc_param #(.LZ_W(LZ_W)) u_lzc (
        .d_i   (lzc_in),
        .cnt_o (lzc_cnt)
    );

    assign lz_in   = lzc_cnt[LZ_W] ? '1 : lzc_cnt[LZ_W-1:0];
    assign emax_in = ER_W'(emax_of(fmt_e'(fmt), ER_W));
    assign ovf_in  = (fr[0] & (er > (emax_in - ER_W'(1))))
                   | (fr[1] & (er >  emax_in))
                   | (fr[2] & (er > (emax_in + ER_W'(1))));

    // Pipeline state
    logic            s1_valid_q, s1_valid_d;
    logic [ER_W-1:0] s1_er_q,    s1_er_d;
    logic [ER_W-1:0] s1_emax_q,  s1_emax_d;
    logic [LZ_W-1:0] s1_lz_q,    s1_lz_d;
    logic            s1_ovf_q,   s1_ovf_d;
    logic            out_valid_q, out_valid_d;
    logic [LZ_W-1:0] lz_q,       lz_d;
    logic            tiny_q,     tiny_d;
    logic            ovf_q,      ovf_d;
    logic            st_tiny_q,  st_tiny_d;
    logic            st_ovf_q,   st_ovf_d;

    logic            s2_adv;
    logic            s1_adv;
    logic            out_hs;
    logic [ER_W-1:0] tiny_sum;

    assign s2_adv   = !out_valid_q || out_ready;
    assign s1_adv   = !s1_valid_q || s2_adv;
    assign in_ready = s1_adv;
    assign out_hs   = out_valid_q && out_ready;

    // Sign of er + emax - lz decides TINY; wrap-around is intended.
    assign tiny_sum = s1_er_q + s1_emax_q - ER_W'(s1_lz_q);

    always_comb begin
        s1_valid_d  = s1_valid_q;
        s1_er_d     = s1_er_q;
        s1_emax_d   = s1_emax_q;
        s1_lz_d     = s1_lz_q;
        s1_ovf_d    = s1_ovf_q;
        out_valid_d = out_valid_q;
        lz_d        = lz_q;
        tiny_d      = tiny_q;
        ovf_d       = ovf_q;

        if (s1_adv) begin
            s1_valid_d = in_valid;
            if (in_valid) begin
                s1_er_d   = er;
                s1_emax_d = emax_in;
                s1_lz_d   = lz_in;
                s1_ovf_d  = ovf_in;
            end
        end

        if (s2_adv) begin
            out_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                lz_d   = s1_lz_q;
                tiny_d = tiny_sum[ER_W-1];
                ovf_d  = s1_ovf_q;
            end
        end

        // Clear first, then OR in the beat leaving this cycle, so a set wins.
        st_tiny_d = (clear_flags ? 1'b0 : st_tiny_q) | (out_hs & tiny_q);
        st_ovf_d  = (clear_flags ? 1'b0 : st_ovf_q)  | (out_hs & ovf_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q  <= 1'b0;
            s1_er_q     <= '0;
            s1_emax_q   <= '0;
            s1_lz_q     <= '0;
            s1_ovf_q    <= 1'b0;
            out_valid_q <= 1'b0;
            lz_q        <= '0;
            tiny_q      <= 1'b0;
            ovf_q       <= 1'b0;
            st_tiny_q   <= 1'b0;
            st_ovf_q    <= 1'b0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_er_q     <= s1_er_d;
            s1_emax_q   <= s1_emax_d;
            s1_lz_q     <= s1_lz_d;
            s1_ovf_q    <= s1_ovf_d;
            out_valid_q <= out_valid_d;
            lz_q        <= lz_d;
            tiny_q      <= tiny_d;
            ovf_q       <= ovf_d;
            st_tiny_q   <= st_tiny_d;
            st_ovf_q    <= st_ovf_d;
        end
    end

    assign out_valid   = out_valid_q;
    assign lz          = lz_q;
    assign tiny        = tiny_q;
    assign ovf1        = ovf_q;
    assign sticky_tiny = st_tiny_q;
    assign sticky_ovf  = st_ovf_q;

endmodule

// File: tb/tb_round_flags_pipe.sv
// tb/tb_round_flags_pipe.sv - directed self-checking bench for round_flags_pipe
module tb_round_flags_pipe;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [56:0] fr;
    logic [12:0] er;
    logic [1:0]  fmt;
    logic        out_valid;
    logic        out_ready;
    logic [5:0]  lz;
    logic        tiny;
    logic        ovf1;
    logic        clear_flags;
    logic        sticky_tiny;
    logic        sticky_ovf;

    int total = 0;
    int bad   = 0;

    round_flags_pipe dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .fr          (fr),
        .er          (er),
        .fmt         (fmt),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .lz          (lz),
        .tiny        (tiny),
        .ovf1        (ovf1),
        .clear_flags (clear_flags),
        .sticky_tiny (sticky_tiny),
        .sticky_ovf  (sticky_ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One beat through an idle pipe: expect it 2 cycles later, then drain.
    task automatic send(input logic [1:0] f, input logic [12:0] e, input logic [56:0] r,
                        input int elz, input logic et, input logic eo, input string tag);
        fmt = f; er = e; fr = r; in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        chk({tag, ".valid"}, 64'(out_valid), 64'd1);
        chk({tag, ".lz"},    64'(lz),        64'(elz));
        chk({tag, ".tiny"},  64'(tiny),      64'(et));
        chk({tag, ".ovf1"},  64'(ovf1),      64'(eo));
        @(posedge clk); #1;
        chk({tag, ".drain"}, 64'(out_valid), 64'd0);
    endtask

    initial begin
        int sent;
        int rcvd;
        int first_hs;
        int last_hs;
        logic [56:0] one;

        one         = 57'd1;
        rst_n       = 1'b0;
        in_valid    = 1'b0;
        out_ready   = 1'b0;
        fr          = '0;
        er          = '0;
        fmt         = 2'b00;
        clear_flags = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        chk("rst.out_valid", 64'(out_valid),   64'd0);
        chk("rst.lz",        64'(lz),          64'd0);
        chk("rst.tiny",      64'(tiny),        64'd0);
        chk("rst.ovf1",      64'(ovf1),        64'd0);
        chk("rst.st_tiny",   64'(sticky_tiny), 64'd0);
        chk("rst.st_ovf",    64'(sticky_ovf),  64'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Directed vectors
        send(2'b00, 13'd100,    one << 56, 0,  1'b0, 1'b0, "s_er100");
        send(2'b00, 13'h1F38,   one << 56, 0,  1'b1, 1'b0, "s_neg200");
        send(2'b01, 13'h1F38,   one << 56, 0,  1'b0, 1'b0, "d_neg200");
        send(2'b11, 13'h1F38,   one << 56, 0,  1'b0, 1'b0, "r_neg200");
        send(2'b00, 13'd127,    57'd1,     56, 1'b0, 1'b1, "s_127_fr0");
        send(2'b00, 13'd127,    57'd2,     55, 1'b0, 1'b0, "s_127_fr1");
        send(2'b00, 13'd128,    57'd2,     55, 1'b0, 1'b1, "s_128_fr1");
        send(2'b10, 13'd16,     57'd4,     54, 1'b1, 1'b0, "h_16_fr2");
        send(2'b10, 13'd17,     57'd4,     54, 1'b1, 1'b1, "h_17_fr2");
        send(2'b00, 13'd100,    one << 50, 6,  1'b0, 1'b0, "lz6");
        send(2'b00, 13'd100,    57'd0,     57, 1'b0, 1'b0, "fr_zero");

        chk("acc.st_tiny", 64'(sticky_tiny), 64'd1);
        chk("acc.st_ovf",  64'(sticky_ovf),  64'd1);

        // Sticky behaviour
        clear_flags = 1'b1;
        @(posedge clk); #1;
        clear_flags = 1'b0;
        chk("clr1.st_tiny", 64'(sticky_tiny), 64'd0);
        chk("clr1.st_ovf",  64'(sticky_ovf),  64'd0);

        send(2'b00, 13'h1F38, one << 56, 0, 1'b1, 1'b0, "st_tiny_beat");
        chk("set.st_tiny", 64'(sticky_tiny), 64'd1);
        chk("set.st_ovf",  64'(sticky_ovf),  64'd0);

        clear_flags = 1'b1;
        @(posedge clk); #1;
        clear_flags = 1'b0;
        chk("clr2.st_tiny", 64'(sticky_tiny), 64'd0);

        send(2'b00, 13'h1F38, one << 56, 0, 1'b1, 1'b0, "st_tiny_beat2");
        chk("set2.st_tiny", 64'(sticky_tiny), 64'd1);

        // ovf1 beat handshaked in the same cycle as clear_flags
        fmt = 2'b00; er = 13'd127; fr = 57'd1; in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        chk("clrhs.valid", 64'(out_valid), 64'd1);
        clear_flags = 1'b1;
        @(posedge clk); #1;
        clear_flags = 1'b0;
        chk("clrhs.st_ovf",  64'(sticky_ovf),  64'd1);
        chk("clrhs.st_tiny", 64'(sticky_tiny), 64'd0);

        // Backpressure: stall 5 cycles, then release with the input still streaming
        sent = 0; rcvd = 0; first_hs = -1; last_hs = -1;
        for (int cyc = 0; cyc < 20; cyc++) begin
            out_ready = (cyc >= 5);
            in_valid  = (sent < 6);
            fmt = 2'b00; er = 13'd100;
            fr  = one << (56 - sent);
            #1;
            if (out_valid && out_ready) begin
                chk("bp.order", 64'(lz), 64'(rcvd));
                if (first_hs < 0) first_hs = cyc;
                last_hs = cyc;
                rcvd++;
            end
            if (!out_ready && out_valid) begin
                chk("bp.hold_lz", 64'(lz), 64'd0);
            end
            if (cyc == 4) begin
                chk("bp.accepted", 64'(sent), 64'd2);
                chk("bp.in_ready", 64'(in_ready), 64'd0);
            end
            if (in_valid && in_ready) sent++;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        chk("bp.rcvd",   64'(rcvd), 64'd6);
        chk("bp.nobubble", 64'(last_hs - first_hs), 64'd5);

        // Reset mid-stream with a full, stalled pipe and a set sticky flag
        out_ready = 1'b0;
        fmt = 2'b00; er = 13'd127; fr = 57'd1; in_valid = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("mid.pre_valid", 64'(out_valid), 64'd1);
        chk("mid.pre_lz",    64'(lz),        64'd56);
        rst_n = 1'b0;
        #1;
        chk("mid.out_valid", 64'(out_valid),   64'd0);
        chk("mid.lz",        64'(lz),          64'd0);
        chk("mid.st_ovf",    64'(sticky_ovf),  64'd0);
        chk("mid.st_tiny",   64'(sticky_tiny), 64'd0);
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("mid.discarded", 64'(out_valid), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
